pipe_hazard_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_perf_cnt.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_BUSY = 2'd1,
    ST_HALT = 2'd2
  } ctrl_state_t;

  localparam int unsigned MDU_LAT_DEF = 4;
  localparam int unsigned MDU_CNT_W   = 4;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Cycle/stall/flush performance counters; each wraps modulo 2^CNT_W.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             in_CLK,
  input  logic             in_CLR_N,
  input  logic             in_cycle_inc,
  input  logic             in_stall_inc,
  input  logic             in_flush_inc,
  output logic [CNT_W-1:0] out_cycle_cnt,
  output logic [CNT_W-1:0] out_stall_cnt,
  output logic [CNT_W-1:0] out_flush_cnt
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  always_ff @(posedge in_CLK) begin
    if (!in_CLR_N) begin
      r_cycle <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (in_cycle_inc) r_cycle <= r_cycle + CNT_W'(1);
      if (in_stall_inc) r_stall <= r_stall + CNT_W'(1);
      if (in_flush_inc) r_flush <= r_flush + CNT_W'(1);
    end
  end

  assign out_cycle_cnt = r_cycle;
  assign out_stall_cnt = r_stall;
  assign out_flush_cnt = r_flush;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, redirect,
// multi-cycle MDU occupancy of EX and syscall halt/resume.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             in_CLK,
  input  logic             in_CLR_N,
  input  logic [4:0]       in_id_rs,
  input  logic [4:0]       in_id_rt,
  input  logic             in_id_use_rs,
  input  logic             in_id_use_rt,
  input  logic             in_ex_memread,
  input  logic [4:0]       in_ex_rd,
  input  logic             in_ex_redirect,
  input  logic             in_ex_mdu_start,
  input  logic             in_wb_halt,
  input  logic             in_go,
  output logic             out_pc_en,
  output logic             out_ifid_en,
  output logic             out_idex_en,
  output logic             out_exmem_en,
  output logic             out_memwb_en,
  output logic             out_ifid_clr,
  output logic             out_idex_clr,
  output logic             out_exmem_clr,
  output logic             out_mdu_done,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_cycle_cnt,
  output logic [CNT_W-1:0] out_stall_cnt,
  output logic [CNT_W-1:0] out_flush_cnt
);

  localparam logic [MDU_CNT_W-1:0] MDU_INIT = MDU_CNT_W'(MDU_LAT - 1);

  ctrl_state_t          r_state;
  logic [MDU_CNT_W-1:0] r_mdu_cnt;
  logic                 r_done;
  logic                 r_resume_busy;

  logic w_load_use;
  logic w_mdu_begin;
  logic w_cycle_inc;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_load_use = in_ex_memread && (in_ex_rd != REG_ZERO) &&
                      ((in_id_use_rs && (in_id_rs == in_ex_rd)) ||
                       (in_id_use_rt && (in_id_rt == in_ex_rd)));

  always_comb begin
    out_pc_en     = 1'b1;
    out_ifid_en   = 1'b1;
    out_idex_en   = 1'b1;
    out_exmem_en  = 1'b1;
    out_memwb_en  = 1'b1;
    out_ifid_clr  = 1'b0;
    out_idex_clr  = 1'b0;
    out_exmem_clr = 1'b0;
    out_mdu_done  = 1'b0;
    out_halted    = 1'b0;
    w_mdu_begin   = 1'b0;
    w_cycle_inc   = 1'b1;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    case (r_state)
      ST_RUN: begin
        out_mdu_done = r_done;
        if (in_wb_halt) begin
          out_pc_en    = 1'b0;
          out_ifid_en  = 1'b0;
          out_idex_en  = 1'b0;
          out_exmem_en = 1'b0;
          out_memwb_en = 1'b0;
        end else if (in_ex_redirect) begin
          out_ifid_clr = 1'b1;
          out_idex_clr = 1'b1;
          w_flush_inc  = 1'b1;
        end else if (in_ex_mdu_start && !r_done) begin
          // A completed op (done flag) lets the same EX instruction advance.
          out_pc_en     = 1'b0;
          out_ifid_en   = 1'b0;
          out_idex_en   = 1'b0;
          out_exmem_clr = 1'b1;
          w_stall_inc   = 1'b1;
          w_mdu_begin   = 1'b1;
        end else if (w_load_use) begin
          out_pc_en    = 1'b0;
          out_ifid_en  = 1'b0;
          out_idex_clr = 1'b1;
          w_stall_inc  = 1'b1;
        end
      end
      ST_BUSY: begin
        out_pc_en   = 1'b0;
        out_ifid_en = 1'b0;
        out_idex_en = 1'b0;
        if (in_wb_halt) begin
          out_exmem_en = 1'b0;
          out_memwb_en = 1'b0;
        end else begin
          out_exmem_clr = 1'b1;
          w_stall_inc   = 1'b1;
        end
      end
      ST_HALT: begin
        out_pc_en    = 1'b0;
        out_ifid_en  = 1'b0;
        out_idex_en  = 1'b0;
        out_exmem_en = 1'b0;
        out_memwb_en = 1'b0;
        out_halted   = 1'b1;
        w_cycle_inc  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_CLK) begin
    if (!in_CLR_N) begin
      r_state       <= ST_RUN;
      r_mdu_cnt     <= '0;
      r_done        <= 1'b0;
      r_resume_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_done && out_idex_en) r_done <= 1'b0;
          if (in_wb_halt) begin
            r_state       <= ST_HALT;
            r_resume_busy <= 1'b0;
          end else if (w_mdu_begin) begin
            r_state   <= ST_BUSY;
            r_mdu_cnt <= MDU_INIT;
          end
        end
        ST_BUSY: begin
          // A halt here freezes the MDU countdown so the op resumes intact.
          if (in_wb_halt) begin
            r_state       <= ST_HALT;
            r_resume_busy <= 1'b1;
          end else if (r_mdu_cnt == MDU_CNT_W'(1)) begin
            r_state   <= ST_RUN;
            r_mdu_cnt <= '0;
            r_done    <= 1'b1;
          end else begin
            r_mdu_cnt <= r_mdu_cnt - MDU_CNT_W'(1);
          end
        end
        ST_HALT: begin
          if (in_go) r_state <= r_resume_busy ? ST_BUSY : ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .in_CLK        (in_CLK),
    .in_CLR_N      (in_CLR_N),
    .in_cycle_inc  (w_cycle_inc),
    .in_stall_inc  (w_stall_inc),
    .in_flush_inc  (w_flush_inc),
    .out_cycle_cnt (out_cycle_cnt),
    .out_stall_cnt (out_stall_cnt),
    .out_flush_cnt (out_flush_cnt)
  );

endmodule
